// File: rtl/divider_config_controller.sv
// -----------------------------------------------------------------------------
// divider_config_controller
//
// Purpose:
//   Arbitrates between two requesters (A, B) that want a new divide ratio
//   loaded into the programmable clock divider. It then drives the divider's
//   configuration interface through the safe sequence:
//     disable -> settle -> load -> acknowledge -> re-enable.
//   The divider is never reprogrammed while it is running. Every output is
//   a register, so there is no combinational path from any input to any
//   output.
//
// Ports:
//   Clk         in   system clock; all logic runs on the rising edge
//   Reset       in   synchronous, active-high; abandons any sequence in flight
//   RunEn       in   level; top-level request for the divider to run
//   ReqA/ReqB   in   request to load DivA/DivB; held until the Ack/Err pulse
//   DivA/DivB   in   requested divisor; sampled once, at grant
//   DinOut      out  divisor presented to the divider Din
//   ConfigDiv   out  one-cycle load strobe to the divider
//   DivEnable   out  divider Enable
//   AckA/AckB   out  one-cycle pulse: divisor loaded
//   ErrA/ErrB   out  one-cycle pulse: request rejected (divisor of zero)
//   Busy        out  high whenever the controller is not idle
//   Configured  out  a valid divisor has been loaded since reset
//   CurDiv      out  last divisor successfully loaded
// -----------------------------------------------------------------------------
module divider_config_controller #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             RunEn,
    input  logic             ReqA,
    input  logic [WIDTH-1:0] DivA,
    input  logic             ReqB,
    input  logic [WIDTH-1:0] DivB,
    output logic [WIDTH-1:0] DinOut,
    output logic             ConfigDiv,
    output logic             DivEnable,
    output logic             AckA,
    output logic             AckB,
    output logic             ErrA,
    output logic             ErrB,
    output logic             Busy,
    output logic             Configured,
    output logic [WIDTH-1:0] CurDiv
);

    // The settle counter is 4 bits wide, which covers the legal range 1..15.
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REJECT,
        S_QUIESCE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_last_b;   // 1: the most recent grant went to B
    logic             r_win_b;    // 1: B owns the sequence in flight
    logic [WIDTH-1:0] r_div;      // divisor latched at grant
    logic [3:0]       r_cnt;      // settle cycles remaining in QUIESCE

    logic             w_grant_b;
    logic [WIDTH-1:0] w_div_win;

    // Round-robin on ties: if both requesters ask at once, the one that did
    // not win last time gets the grant. Otherwise the sole requester wins.
    assign w_grant_b = ReqB & (~ReqA | ~r_last_b);
    assign w_div_win = w_grant_b ? DivB : DivA;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_last_b   <= 1'b1;       // A wins the first tie after reset
            r_win_b    <= 1'b0;
            r_div      <= '0;
            r_cnt      <= '0;
            DinOut     <= '0;
            ConfigDiv  <= 1'b0;
            DivEnable  <= 1'b0;
            AckA       <= 1'b0;
            AckB       <= 1'b0;
            ErrA       <= 1'b0;
            ErrB       <= 1'b0;
            Busy       <= 1'b0;
            Configured <= 1'b0;
            CurDiv     <= '0;
        end else begin
            // Ack/Err are single-cycle pulses; only the transition that
            // raises one of them overrides this default.
            AckA <= 1'b0;
            AckB <= 1'b0;
            ErrA <= 1'b0;
            ErrB <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (ReqA | ReqB) begin
                        r_last_b <= w_grant_b;
                        r_win_b  <= w_grant_b;
                        r_div    <= w_div_win;
                        Busy     <= 1'b1;
                        if (w_div_win == '0) begin
                            // The divider is left untouched, so DivEnable
                            // keeps its current value through the rejection.
                            r_state <= S_REJECT;
                            ErrA    <= ~w_grant_b;
                            ErrB    <= w_grant_b;
                        end else begin
                            r_state   <= S_QUIESCE;
                            DivEnable <= 1'b0;
                            r_cnt     <= SETTLE_INIT;
                        end
                    end else begin
                        DivEnable <= RunEn & Configured;
                    end
                end

                S_REJECT: begin
                    r_state <= S_IDLE;
                    Busy    <= 1'b0;
                end

                S_QUIESCE: begin
                    // Entered with r_cnt = SETTLE_CYCLES, so the state lasts
                    // exactly SETTLE_CYCLES cycles before the load strobe.
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_state   <= S_LOAD;
                        ConfigDiv <= 1'b1;
                        DinOut    <= r_div;
                    end
                end

                S_LOAD: begin
                    // Configured and CurDiv become visible together with Ack.
                    r_state    <= S_DONE;
                    ConfigDiv  <= 1'b0;
                    AckA       <= ~r_win_b;
                    AckB       <= r_win_b;
                    Configured <= 1'b1;
                    CurDiv     <= r_div;
                end

                S_DONE: begin
                    // Re-enable is decided from RunEn sampled here, so the
                    // first IDLE cycle already reflects it. DinOut is left
                    // holding the loaded divisor.
                    r_state   <= S_IDLE;
                    Busy      <= 1'b0;
                    DivEnable <= RunEn & Configured;
                end

                default: begin
                    r_state <= S_IDLE;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_config_controller.sv
// -----------------------------------------------------------------------------
// tb_divider_config_controller
//
// Purpose:
//   Self-checking bench for divider_config_controller. The stimulus side
//   predicts, from the arbitration and loading rules, which requester is
//   served in what order and with what outcome, and pushes that into a queue.
//   A monitor pops an entry whenever an Ack/Err pulse appears, and checks
//   the load strobe against the head of the queue. Directed sequences cover
//   exact latencies, rejection, reset during a load and RunEn handling.
//   Randomized rounds follow them.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_divider_config_controller;

    localparam int W = 32;
    localparam int S = 2;

    logic         Clk = 1'b0;
    logic         Reset, RunEn, ReqA, ReqB;
    logic [W-1:0] DivA, DivB;
    logic [W-1:0] DinOut, CurDiv;
    logic         ConfigDiv, DivEnable, AckA, AckB, ErrA, ErrB, Busy, Configured;

    divider_config_controller #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .Clk(Clk), .Reset(Reset), .RunEn(RunEn),
        .ReqA(ReqA), .DivA(DivA), .ReqB(ReqB), .DivB(DivB),
        .DinOut(DinOut), .ConfigDiv(ConfigDiv), .DivEnable(DivEnable),
        .AckA(AckA), .AckB(AckB), .ErrA(ErrA), .ErrB(ErrB),
        .Busy(Busy), .Configured(Configured), .CurDiv(CurDiv)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: the order of service and the outcome of each grant.
    typedef struct {
        bit           is_b;
        bit           err;
        logic [W-1:0] div;
        logic [W-1:0] cur;
        bit           cfg;
    } exp_t;

    exp_t         q[$];
    bit           m_last_b;
    bit           m_cfg;
    logic [W-1:0] m_cur;

    function automatic void model_reset();
        m_last_b = 1'b1;
        m_cfg    = 1'b0;
        m_cur    = '0;
        q.delete();
    endfunction

    function automatic void model_grant(bit b, logic [W-1:0] d);
        exp_t e;
        e.is_b = b;
        e.err  = (d == 0);
        e.div  = d;
        if (d != 0) begin
            m_cur = d;
            m_cfg = 1'b1;
        end
        e.cur    = m_cur;
        e.cfg    = m_cfg;
        m_last_b = b;
        q.push_back(e);
    endfunction

    // Raise requests at a negedge and record the expected service order.
    task automatic issue(input bit ra, input bit rb, input logic [W-1:0] da, input logic [W-1:0] db);
        bit wb;
        DivA = da;
        DivB = db;
        ReqA = ra;
        ReqB = rb;
        if (ra && rb) begin
            wb = !m_last_b;
            model_grant(wb, wb ? db : da);
            model_grant(!wb, wb ? da : db);
        end else if (rb) begin
            model_grant(1'b1, db);
        end else begin
            model_grant(1'b0, da);
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge Clk);
            if (!ReqA && !ReqB && !Busy) done = 1'b1;
        end
        chk("round_complete", done, 1);
    endtask

    // While idle, DivEnable follows RunEn & Configured one cycle later.
    task automatic idle_track(input int n);
        bit r;
        for (int i = 0; i < n; i++) begin
            r = 1'($urandom % 2);
            RunEn = r;
            @(negedge Clk);
            chk("en_track", DivEnable, r & m_cfg);
        end
    endtask

    function automatic logic [W-1:0] rnd_div();
        case ($urandom % 5)
            0:       return '0;
            1:       return 1;
            2:       return W'($urandom_range(2, 20));
            default: return W'($urandom);
        endcase
    endfunction

    // Requester behaviour: drop the request once its pulse is seen.
    initial begin
        forever begin
            @(negedge Clk);
            if (AckA || ErrA) ReqA = 1'b0;
            if (AckB || ErrB) ReqB = 1'b0;
        end
    end

    // Monitor: pops the scoreboard on every Ack/Err pulse.
    int   mon_cnt;
    exp_t mon_e;
    logic [3:0] mon_pat, mon_exp;
    initial begin
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                mon_cnt = int'(AckA) + int'(AckB) + int'(ErrA) + int'(ErrB);
                mon_pat = {AckA, AckB, ErrA, ErrB};
                if (mon_cnt > 1) chk("one_pulse", mon_cnt, 1);
                if (mon_cnt == 1) begin
                    if (q.size() == 0) begin
                        chk("unexpected_pulse", mon_pat, 0);
                    end else begin
                        mon_e   = q.pop_front();
                        mon_exp = mon_e.err ? (mon_e.is_b ? 4'b0001 : 4'b0010)
                                            : (mon_e.is_b ? 4'b0100 : 4'b1000);
                        chk("pulse_who", mon_pat, mon_exp);
                        chk("curdiv", CurDiv, mon_e.cur);
                        chk("configured", Configured, mon_e.cfg);
                        if (!mon_e.err) chk("en_low_at_ack", DivEnable, 0);
                    end
                end
                if (ConfigDiv) begin
                    chk("en_low_at_load", DivEnable, 0);
                    if (q.size() > 0) chk("dinout", DinOut, q[0].div);
                    else              chk("spurious_config", ConfigDiv, 0);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit hit;
        Reset = 1'b1; RunEn = 1'b0; ReqA = 1'b0; ReqB = 1'b0; DivA = '0; DivB = '0;
        model_reset();
        repeat (3) @(negedge Clk);
        chk("rst_dinout", DinOut, 0);
        chk("rst_config", ConfigDiv, 0);
        chk("rst_enable", DivEnable, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_configured", Configured, 0);
        chk("rst_curdiv", CurDiv, 0);
        chk("rst_pulses", {AckA, AckB, ErrA, ErrB}, 0);

        // RunEn before any configuration must not enable the divider.
        Reset = 1'b0;
        RunEn = 1'b1;
        repeat (4) begin
            @(negedge Clk);
            chk("en_before_cfg", DivEnable, 0);
            chk("cfg_before_load", Configured, 0);
        end

        // Exact latency of a single load (SETTLE = 2).
        issue(1, 0, 4, 0);
        @(negedge Clk); chk("lat_en_low", DivEnable, 0); chk("lat_busy", Busy, 1);
        @(negedge Clk); chk("lat_no_cfg_yet", ConfigDiv, 0);
        @(negedge Clk); chk("lat_cfg", ConfigDiv, 1); chk("lat_din", DinOut, 4);
        @(negedge Clk); chk("lat_ack", AckA, 1); chk("lat_cur", CurDiv, 4); chk("lat_din_hold", DinOut, 4);
        @(negedge Clk); chk("lat_reenable", DivEnable, 1); chk("lat_idle", Busy, 0);
        wait_idle();

        // Ties: A first after reset, and B is still served each time.
        issue(1, 1, 6, 10);
        wait_idle();
        issue(1, 1, 6, 10);
        wait_idle();

        // Rejection while running at divisor 4.
        issue(1, 0, 4, 0);
        wait_idle();
        RunEn = 1'b1;
        @(negedge Clk);
        issue(0, 1, 0, 0);
        @(negedge Clk);
        chk("rej_err", ErrB, 1);
        chk("rej_en_held", DivEnable, 1);
        chk("rej_no_cfg", ConfigDiv, 0);
        chk("rej_cur", CurDiv, 4);
        @(negedge Clk);
        chk("rej_en_after", DivEnable, 1);
        chk("rej_no_cfg2", ConfigDiv, 0);
        wait_idle();

        // Reset arriving during the load cycle.
        issue(1, 0, 7, 0);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge Clk);
            if (ConfigDiv) hit = 1'b1;
        end
        chk("reached_load", hit, 1);
        Reset = 1'b1;
        ReqA  = 1'b0;
        @(negedge Clk);
        chk("rl_config", ConfigDiv, 0);
        chk("rl_dinout", DinOut, 0);
        chk("rl_enable", DivEnable, 0);
        chk("rl_ack", AckA, 0);
        chk("rl_busy", Busy, 0);
        chk("rl_configured", Configured, 0);
        chk("rl_curdiv", CurDiv, 0);
        model_reset();
        Reset = 1'b0;
        @(negedge Clk);
        issue(1, 0, 3, 0);
        wait_idle();

        // RunEn wiggling and DivA changing after grant.
        RunEn = 1'b1;
        issue(1, 0, 9, 0);
        @(negedge Clk); chk("busy_en_q1", DivEnable, 0); DivA = 55; RunEn = 1'b0;
        @(negedge Clk); chk("busy_en_q2", DivEnable, 0); RunEn = 1'b1;
        @(negedge Clk); chk("busy_en_load", DivEnable, 0); RunEn = 1'b0;
        @(negedge Clk); chk("busy_en_done", DivEnable, 0); RunEn = 1'b1;
        @(negedge Clk); chk("post_en", DivEnable, 1); chk("post_cur", CurDiv, 9);
        wait_idle();
        idle_track(6);

        // Randomized rounds.
        for (int r = 0; r < 25; r++) begin
            bit ra, rb;
            ra = 1'($urandom % 2);
            rb = 1'($urandom % 2);
            if (!ra && !rb) ra = 1'b1;
            RunEn = 1'($urandom % 2);
            issue(ra, rb, rnd_div(), rnd_div());
            wait_idle();
            idle_track(3);
        end

        repeat (3) @(negedge Clk);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/divider_config_controller.md
Name: divider_config_controller

Overview:
- Sequences the programmable clock divider: arbitrates between two requesters (A, B) asking for a new divide ratio, then runs the safe reprogramming sequence on the divider's configuration interface (Din, ConfigDiv, Enable).
- The sequence is always disable, settle, load, acknowledge, re-enable. It is never applied while the divider is running.
- Sits between the divider and its client blocks. The divider's own reset is driven elsewhere.

Parameters:
- WIDTH, 32, width of divisor buses (matches divider Din).
- SETTLE_CYCLES, 2, cycles Enable is held low before ConfigDiv (legal range 1..15).

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- RunEn  in  1  level; top-level request for divider to run.
- ReqA  in  1  requester A wants divisor DivA loaded; held until AckA/ErrA.
- DivA  in  WIDTH  requested divisor A; stable while ReqA high.
- ReqB  in  1  as ReqA for requester B.
- DivB  in  WIDTH  as DivA for requester B.
- DinOut  out  WIDTH  to divider Din.
- ConfigDiv  out  1  to divider ConfigDiv.
- DivEnable  out  1  to divider Enable.
- AckA, AckB  out  1  one-cycle pulse: divisor loaded.
- ErrA, ErrB  out  1  one-cycle pulse: request rejected (divisor 0).
- Busy  out  1  high whenever state != IDLE.
- Configured  out  1  a valid divisor has been loaded since reset.
- CurDiv  out  WIDTH  last divisor successfully loaded.

Behaviour:
- All outputs are registers. No combinational input-to-output path.
- Reset (synchronous, applies mid-sequence):
  - State=IDLE; DinOut=0, ConfigDiv=0, DivEnable=0, Ack*/Err*=0, Busy=0, Configured=0, CurDiv=0.
  - LastGrant=B, so A wins the first tie.
  - The partially completed sequence is abandoned; no Ack/Err is issued for it.
- States: IDLE, REJECT, QUIESCE, LOAD, DONE.
- IDLE:
  - DivEnable <= RunEn & Configured each cycle (one-cycle latency from RunEn).
  - If ReqA|ReqB, grant:
    - Single requester: that requester wins.
    - Both requesting: the requester opposite LastGrant wins.
    - LastGrant <= winner. Latch the winner's divisor into an internal register. Busy <= 1.
  - Latched divisor == 0: go to REJECT. DivEnable holds its current value.
  - Latched divisor != 0: go to QUIESCE. DivEnable <= 0. Settle counter <= SETTLE_CYCLES.
- REJECT: one cycle, Err of winner = 1. Divider outputs, Configured and CurDiv unchanged. Next state IDLE.
- QUIESCE: DivEnable=0, ConfigDiv=0. Counter decrements each cycle; the state lasts exactly SETTLE_CYCLES cycles, then goes to LOAD.
- LOAD: one cycle, ConfigDiv=1, DinOut=latched divisor, DivEnable=0. Next state DONE.
- DONE: one cycle.
  - ConfigDiv=0. DinOut holds its value (not cleared). DivEnable=0.
  - Ack of winner = 1. Configured <= 1. CurDiv <= latched divisor.
  - Next state IDLE.
- Latency: request sampled in IDLE cycle n gives:
  - DivEnable low from n+1.
  - ConfigDiv high in n+SETTLE_CYCLES+1.
  - Ack in n+SETTLE_CYCLES+2.
  - DivEnable re-asserts in n+SETTLE_CYCLES+3 if RunEn is high.
- Requester protocol: a requester deasserts Req in the cycle after its Ack/Err pulse. The controller does not re-sample Req until it is back in IDLE, so there is no double grant.
- Req dropped mid-sequence: the sequence still completes and Ack/Err still pulses. The divisor is latched, so DivA/DivB changes after the grant are ignored.
- RunEn changes while Busy: ignored until IDLE; DivEnable stays 0 throughout QUIESCE/LOAD/DONE.
- RunEn high before any configuration: DivEnable stays 0 (Configured=0).
- Divisor 1 is legal (divider pass-through mode). No upper bound check.
- Ack and Err are never high together. At most one of AckA/AckB/ErrA/ErrB is high in any cycle.

Test Plan:
- Reset, RunEn=1, no requests -> DivEnable stays 0, Configured=0. Then ReqA with DivA=4 at cycle 10 (SETTLE=2):
  - DivEnable=0 at 11.
  - ConfigDiv=1 with DinOut=4 at 13.
  - AckA at 14, CurDiv=4.
  - DivEnable=1 at 15.
- ReqA (DivA=6) and ReqB (DivB=10) raised in the same cycle, held per protocol:
  - After reset, A granted first and B second.
  - Repeat the tie: B is not starved; grants alternate.
- ReqB with DivB=0 while running at divisor 4 -> ErrB pulse one cycle after grant; DivEnable stays 1; CurDiv stays 4; no ConfigDiv.
- Reset asserted in the cycle the FSM is in LOAD:
  - Next cycle all outputs are at reset values; no Ack; Configured=0.
  - A fresh ReqA then completes normally.
- RunEn toggled low/high during QUIESCE, and DivA changed after grant:
  - DivEnable=0 throughout QUIESCE/LOAD/DONE.
  - Loaded value equals the DivA sampled at grant.
  - After IDLE, DivEnable tracks RunEn with one-cycle latency.
